// File: rtl/led_counter_pkg.sv
// led_counter_pkg: shared definitions for the multi-mode LED counter.
//   - Display mode encodings (MODE_UP, MODE_DOWN, MODE_GRAY, MODE_BOUNCE)
//   - Bounce direction encodings
//   - bin2gray(): binary to reflected Gray code. It works on a 64-bit
//     value so callers of any width up to 64 can zero-extend in and
//     truncate out. Zero-extension leaves the low Gray bits unchanged.
package led_counter_pkg;

    localparam logic [1:0] MODE_UP     = 2'd0;
    localparam logic [1:0] MODE_DOWN   = 2'd1;
    localparam logic [1:0] MODE_GRAY   = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [63:0] bin2gray(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/led_counter_multi_tick_gen.sv
// tick_gen: display-update prescaler.
//   Parameter:
//     TICK_CYCLES - clock cycles per update (must be >= 2)
//   Ports:
//     clk      - system clock
//     rst_n    - asynchronous active-low reset
//     en       - count enable. While low, pcnt holds its phase and is not cleared.
//     clear    - synchronous restart of the phase at 0. Has priority over en.
//     tick_int - combinational, high in the cycle whose edge wraps pcnt
module tick_gen #(
    parameter int TICK_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tick_int
);

    localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] pcnt;

    assign tick_int = en && (pcnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (clear) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_counter_multi.sv
// led_counter_multi: multi-mode LED counter driven by a periodic update tick.
//   Parameters:
//     CLK_FREQ    - input clock frequency in Hz
//     WIDTH       - LED bank width (>= 2, <= 64)
//     TICK_CYCLES - clock cycles per display update (default: half a second)
//   Ports:
//     clk   - system clock
//     rst_n - asynchronous active-low reset
//     mode  - 0 up, 1 down, 2 Gray, 3 bounce
//     en    - 1 free-run, 0 paused
//     step  - while paused, a one-cycle pulse advances one update
//     leds  - registered LED pattern
//     tick  - one-cycle pulse on every display update
//     wrap  - one-cycle pulse when the sequence wraps or reverses
//   Build option:
//     LED_COUNTER_BOUNCE_EN - builds the bounce walk for mode 3. Without this
//     macro, mode 3 counts like mode 0. A change between modes 0 and 3 still
//     reloads the counter.
//
// A mode change is detected as mode != mode_q. It outranks any tick or
// step on the same edge. It reloads the new mode's initial pattern,
// restarts the prescaler and suppresses tick/wrap.
module led_counter_multi
    import led_counter_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int WIDTH       = 8,
    parameter int TICK_CYCLES = CLK_FREQ / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             step,
    output logic [WIDTH-1:0] leds,
    output logic             tick,
    output logic             wrap
);

    logic [1:0]       mode_q;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] leds_nxt;
    logic             wrap_nxt;
    logic             tick_int;
    logic             mode_chg;
    logic             adv;

    assign mode_chg = (mode != mode_q);
    // tick_int is only asserted while en=1, so step cannot double up with it.
    assign adv = !mode_chg && (tick_int || (!en && step));

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clear    (mode_chg),
        .tick_int (tick_int)
    );

`ifdef LED_COUNTER_BOUNCE_EN
    logic dir;
    logic dir_nxt;
`endif

    always_comb begin
        bin_nxt  = bin;
        leds_nxt = leds;
        wrap_nxt = 1'b0;
`ifdef LED_COUNTER_BOUNCE_EN
        dir_nxt  = dir;
`endif
        if (mode_chg) begin
            bin_nxt  = '0;
            leds_nxt = '0;
`ifdef LED_COUNTER_BOUNCE_EN
            dir_nxt  = DIR_UP;
            if (mode == MODE_BOUNCE) begin
                leds_nxt = WIDTH'(1);
            end
`endif
        end else if (adv) begin
            case (mode_q)
                MODE_DOWN: begin
                    bin_nxt  = bin - 1'b1;
                    leds_nxt = bin_nxt;
                    wrap_nxt = (bin == '0);
                end
                MODE_GRAY: begin
                    bin_nxt  = bin + 1'b1;
                    leds_nxt = WIDTH'(bin2gray(64'(bin_nxt)));
                    wrap_nxt = &bin;
                end
`ifdef LED_COUNTER_BOUNCE_EN
                MODE_BOUNCE: begin
                    // The one-hot pattern lives in leds itself; bin is unused here.
                    if (dir == DIR_UP) begin
                        leds_nxt = leds << 1;
                        if (leds_nxt[WIDTH-1]) begin
                            dir_nxt  = DIR_DOWN;
                            wrap_nxt = 1'b1;
                        end
                    end else begin
                        leds_nxt = leds >> 1;
                        if (leds_nxt[0]) begin
                            dir_nxt  = DIR_UP;
                            wrap_nxt = 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    bin_nxt  = bin + 1'b1;
                    leds_nxt = bin_nxt;
                    wrap_nxt = &bin;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_UP;
            bin    <= '0;
            leds   <= '0;
            tick   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            mode_q <= mode;
            bin    <= bin_nxt;
            leds   <= leds_nxt;
            tick   <= adv;
            wrap   <= wrap_nxt;
        end
    end

`ifdef LED_COUNTER_BOUNCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir <= DIR_UP;
        end else begin
            dir <= dir_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_led_counter_multi.sv
module tb_led_counter_multi;

    localparam int W  = 8;
    localparam int TC = 5;

    logic         clk;
    logic         rst_n;
    logic [1:0]   mode;
    logic         en;
    logic         step;
    logic [W-1:0] leds;
    logic         tick;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    // Reference model state:
    //   m_mode - mode the current sequence runs in
    //   m_n    - number of updates since the last reload
    //   m_ph   - enabled edges since the last reload (the prescaler phase)
    logic [1:0] m_mode;
    int         m_n;
    int         m_ph;
    logic       m_tick;
    logic       m_wrap;
    int         edge_err;
    int         wrap_cnt;

    led_counter_multi #(
        .CLK_FREQ(10),
        .WIDTH   (W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mode (mode),
        .en   (en),
        .step (step),
        .leds (leds),
        .tick (tick),
        .wrap (wrap)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected LED pattern after n updates in mode m, worked out from the mode rules.
    function automatic logic [W-1:0] exp_leds(input logic [1:0] m, input int n);
        logic [W-1:0] b;
        int p;
        b = W'(n);
        case (m)
            2'd1: return W'(0 - n);
            2'd2: return b ^ (b >> 1);
            2'd3: begin
`ifdef LED_COUNTER_BOUNCE_EN
                p = n % (2 * W - 2);
                if (p <= W - 1) return W'(1 << p);
                return W'(1 << (2 * W - 2 - p));
`else
                p = 0;
                return b;
`endif
            end
            default: return b;
        endcase
    endfunction

    function automatic logic exp_wrap_at(input logic [1:0] m, input int n);
        case (m)
            2'd1: return (n % (1 << W)) == 1;
`ifdef LED_COUNTER_BOUNCE_EN
            2'd3: return (n % (W - 1)) == 0;
`endif
            default: return (n % (1 << W)) == 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 2'd0;
        m_n    = 0;
        m_ph   = 0;
        m_tick = 1'b0;
        m_wrap = 1'b0;
    endtask

    // Advance n clock edges. The model sees the inputs applied at each edge.
    // Outputs are sampled 1 time unit after the edge. Edges where tick/wrap
    // disagree with the model are tallied in edge_err.
    task automatic clk_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            m_tick = 1'b0;
            m_wrap = 1'b0;
            if (mode != m_mode) begin
                m_mode = mode;
                m_n    = 0;
                m_ph   = 0;
            end else if (en) begin
                m_ph++;
                if (m_ph % TC == 0) begin
                    m_n++;
                    m_tick = 1'b1;
                    m_wrap = exp_wrap_at(m_mode, m_n);
                end
            end else if (step) begin
                m_n++;
                m_tick = 1'b1;
                m_wrap = exp_wrap_at(m_mode, m_n);
            end
            #1;
            if (tick !== m_tick || wrap !== m_wrap) edge_err++;
            if (wrap === 1'b1) wrap_cnt++;
        end
    endtask

    // Assert reset for a short while and release it 1 unit after a rising edge.
    task automatic do_reset(input logic [1:0] m);
        mode  = m;
        en    = 1'b1;
        step  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        edge_err = 0;
        wrap_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset(2'd0);
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL reset_leds: got %h expected 00", leds);
        end
        checks++;
        if (tick !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got tick=%b wrap=%b expected 0 0", tick, wrap);
        end
    endtask

    task automatic test_up();
        do_reset(2'd0);
        clk_edges(4);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL up_no_tick_edge4: got tick=%b expected 0", tick);
        end
        clk_edges(1);
        checks++;
        if (tick !== 1'b1 || leds !== 8'h01) begin
            errors++;
            $display("FAIL up_first_update: got tick=%b leds=%h expected 1 01", tick, leds);
        end
        clk_edges(10);
        checks++;
        if (leds !== 8'h03 || wrap_cnt != 0) begin
            errors++;
            $display("FAIL up_15_edges: got leds=%h wraps=%0d expected 03 0", leds, wrap_cnt);
        end
        clk_edges(1280 - 15);
        checks++;
        if (leds !== 8'h00 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL up_wrap: got leds=%h wrap=%b expected 00 1", leds, wrap);
        end
        checks++;
        if (edge_err != 0) begin
            errors++;
            $display("FAIL up_pulses: got %0d bad edges expected 0", edge_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2'd0);
        clk_edges(7);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_async: got %h expected 00", leds);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clk_edges(10);
        checks++;
        if (leds !== 8'h02) begin
            errors++;
            $display("FAIL mid_reset_10: got %h expected 02", leds);
        end
        clk_edges(40);
        checks++;
        if (leds !== 8'h0A) begin
            errors++;
            $display("FAIL mid_reset_50: got %h expected 0a", leds);
        end
    endtask

    task automatic test_down();
        do_reset(2'd1);
        clk_edges(1);
        checks++;
        if (leds !== 8'h00 || tick !== 1'b0) begin
            errors++;
            $display("FAIL down_reload: got leds=%h tick=%b expected 00 0", leds, tick);
        end
        clk_edges(5);
        checks++;
        if (leds !== 8'hFF || wrap !== 1'b1) begin
            errors++;
            $display("FAIL down_first: got leds=%h wrap=%b expected ff 1", leds, wrap);
        end
        clk_edges(5);
        checks++;
        if (leds !== 8'hFE || wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_second: got leds=%h wrap=%b expected fe 0", leds, wrap);
        end
    endtask

    task automatic test_gray();
        do_reset(2'd2);
        clk_edges(1);
        clk_edges(20);
        checks++;
        if (leds !== 8'h06) begin
            errors++;
            $display("FAIL gray_bin4: got %h expected 06", leds);
        end
        clk_edges(15);
        checks++;
        if (leds !== 8'h04) begin
            errors++;
            $display("FAIL gray_bin7: got %h expected 04", leds);
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] e7, e8, e14;
        logic         w7, w14;
`ifdef LED_COUNTER_BOUNCE_EN
        e7 = 8'h80; e8 = 8'h40; e14 = 8'h01; w7 = 1'b1; w14 = 1'b1;
`else
        e7 = 8'h07; e8 = 8'h08; e14 = 8'h0E; w7 = 1'b0; w14 = 1'b0;
`endif
        do_reset(2'd3);
        clk_edges(1);
        clk_edges(35);
        checks++;
        if (leds !== e7 || wrap !== w7) begin
            errors++;
            $display("FAIL bounce_u7: got leds=%h wrap=%b expected %h %b", leds, wrap, e7, w7);
        end
        clk_edges(5);
        checks++;
        if (leds !== e8) begin
            errors++;
            $display("FAIL bounce_u8: got %h expected %h", leds, e8);
        end
        clk_edges(30);
        checks++;
        if (leds !== e14 || wrap !== w14) begin
            errors++;
            $display("FAIL bounce_u14: got leds=%h wrap=%b expected %h %b", leds, wrap, e14, w14);
        end
        checks++;
        if (edge_err != 0) begin
            errors++;
            $display("FAIL bounce_pulses: got %0d bad edges expected 0", edge_err);
        end
    endtask

    task automatic test_pause_step();
        do_reset(2'd0);
        clk_edges(3);
        en = 1'b0;
        clk_edges(50);
        checks++;
        if (leds !== 8'h00 || edge_err != 0) begin
            errors++;
            $display("FAIL pause_hold: got leds=%h bad_edges=%0d expected 00 0", leds, edge_err);
        end
        step = 1'b1;
        clk_edges(1);
        step = 1'b0;
        checks++;
        if (leds !== 8'h01 || tick !== 1'b1) begin
            errors++;
            $display("FAIL step_advance: got leds=%h tick=%b expected 01 1", leds, tick);
        end
        en = 1'b1;
        clk_edges(1);
        checks++;
        if (tick !== 1'b0 || leds !== 8'h01) begin
            errors++;
            $display("FAIL resume_early: got tick=%b leds=%h expected 0 01", tick, leds);
        end
        clk_edges(1);
        checks++;
        if (tick !== 1'b1 || leds !== 8'h02) begin
            errors++;
            $display("FAIL resume_update: got tick=%b leds=%h expected 1 02", tick, leds);
        end
        step = 1'b1;
        clk_edges(1);
        step = 1'b0;
        checks++;
        if (tick !== 1'b0 || leds !== 8'h02) begin
            errors++;
            $display("FAIL step_ignored_en: got tick=%b leds=%h expected 0 02", tick, leds);
        end
    endtask

    task automatic test_mode_change_on_tick();
        do_reset(2'd0);
        clk_edges(4);
        mode = 2'd2;
        clk_edges(1);
        checks++;
        if (leds !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL mode_chg_on_tick: got leds=%h tick=%b wrap=%b expected 00 0 0", leds, tick, wrap);
        end
        clk_edges(5);
        checks++;
        if (leds !== 8'h01 || tick !== 1'b1) begin
            errors++;
            $display("FAIL mode_chg_restart: got leds=%h tick=%b expected 01 1", leds, tick);
        end
    endtask

    task automatic test_random();
        do_reset(2'($urandom_range(0, 3)));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) en = ~en;
            step = ($urandom_range(0, 3) == 0);
            clk_edges(1);
            checks++;
            if (leds !== exp_leds(m_mode, m_n) || tick !== m_tick || wrap !== m_wrap) begin
                errors++;
                $display("FAIL random_edge%0d: got leds=%h tick=%b wrap=%b expected %h %b %b",
                         i, leds, tick, wrap, exp_leds(m_mode, m_n), m_tick, m_wrap);
            end
        end
        step = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        mode     = 2'd0;
        en       = 1'b1;
        step     = 1'b0;
        edge_err = 0;
        wrap_cnt = 0;
        model_reset();
        test_reset();
        test_up();
        test_reset_mid();
        test_down();
        test_gray();
        test_bounce();
        test_pause_step();
        test_mode_change_on_tick();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
